// File: rtl/program_loader.sv
// Receives a length-prefixed, XOR-checksummed program image byte stream and
// writes it into instruction memory as little-endian 32-bit words.
module program_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [31:0]         length;
  logic [7:0]          checksum;
  logic [23:0]         word_buf;
  logic [31:0]         len_full;
  logic [ADDR_WIDTH:0] wc_inc;

  // Length as it will be once the current (4th) length byte lands.
  assign len_full = {rx_data, length[23:0]};
  assign wc_inc   = word_count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      length     <= '0;
      checksum   <= '0;
      word_buf   <= '0;
      imem_wren  <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      imem_wren <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN;
            byte_cnt   <= '0;
            length     <= '0;
            checksum   <= '0;
            word_count <= '0;
            imem_addr  <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
          end
        end
        LEN: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    length[7:0]   <= rx_data;
              2'd1:    length[15:8]  <= rx_data;
              2'd2:    length[23:16] <= rx_data;
              default: length[31:24] <= rx_data;
            endcase
            if (byte_cnt == 2'd3) begin
              if (len_full == 32'd0 || len_full > MAX_WORDS) begin
                state <= ERR;
                error <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            checksum <= checksum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                imem_wren  <= 1'b1;
                imem_wdata <= {rx_data, word_buf};
                imem_addr  <= word_count[ADDR_WIDTH-1:0];
                word_count <= wc_inc;
                if (32'(wc_inc) == length) state <= CSUM;
              end
            endcase
          end
        end
        CSUM: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == checksum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of whole images plus hand-written
// reset-mid-load and start-interleaved sequences.
module tb_program_loader;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          imem_wren;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_wren  (imem_wren),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Every cycle with the write strobe high is one memory write.
  int wr_count = 0;
  always @(negedge clk) if (imem_wren) wr_count <= wr_count + 1;

  int total_checks = 0;
  int pass_checks  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) pass_checks++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_start);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0);
  endtask

  // Sends one word; the write must be visible right after the 4th byte's edge.
  task automatic send_word(input logic [31:0] w, input int idx, input logic start_mid);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], start_mid && (i == 1));
    check($sformatf("wren%0d", idx), {63'd0, imem_wren}, 64'd1);
    check($sformatf("addr%0d", idx), {50'd0, imem_addr}, 64'(idx));
    check($sformatf("wdata%0d", idx), {32'd0, imem_wdata}, {32'd0, w});
  endtask

  task automatic check_end(input string tag, input logic exp_done, input logic exp_err,
                           input int exp_wc, input int exp_writes, input int base);
    check({tag, "_done"},   {63'd0, done},   {63'd0, exp_done});
    check({tag, "_error"},  {63'd0, error},  {63'd0, exp_err});
    check({tag, "_busy"},   {63'd0, busy},   64'd0);
    check({tag, "_wc"},     {49'd0, word_count}, 64'(exp_wc));
    check({tag, "_writes"}, 64'(wr_count - base), 64'(exp_writes));
    check({tag, "_wren0"},  {63'd0, imem_wren}, 64'd0);
  endtask

  typedef struct {
    logic [31:0] len;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    vecs[0] = '{32'd2,          2, 32'h00100513, 32'h00200593, 8'hB0, 1'b1, 1'b0};
    vecs[1] = '{32'd2,          2, 32'h00100513, 32'h00200593, 8'hB1, 1'b0, 1'b1};
    vecs[2] = '{32'd0,          0, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_4001,  0, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1};
    vecs[4] = '{32'd1,          1, 32'hDEADBEEF, 32'h0,        8'h22, 1'b1, 1'b0};
    vecs[5] = '{32'h0100_0001,  0, 32'h0,        32'h0,        8'h00, 1'b0, 1'b1};

    repeat (3) tick();
    check("rst_wren",  {63'd0, imem_wren}, 64'd0);
    check("rst_addr",  {50'd0, imem_addr}, 64'd0);
    check("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    check("rst_flags", {61'd0, busy, done, error}, 64'd0);
    check("rst_wc",    {49'd0, word_count}, 64'd0);
    rst = 1'b0;
    tick();
    send_byte(8'h55, 1'b0);
    check("idle_rx_ignored", {62'd0, busy, imem_wren}, 64'd0);

    for (int v = 0; v < 6; v++) begin
      base = wr_count;
      pulse_start();
      check($sformatf("v%0d_busy_start", v), {61'd0, busy, done, error}, 64'd4);
      check($sformatf("v%0d_wc_start", v), {49'd0, word_count}, 64'd0);
      send_len(vecs[v].len);
      if (vecs[v].nwords == 0) begin
        check($sformatf("v%0d_err_now", v), {62'd0, error, busy}, 64'd2);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
      end else begin
        send_word(vecs[v].w0, 0, 1'b0);
        if (vecs[v].nwords > 1) send_word(vecs[v].w1, 1, 1'b0);
        check($sformatf("v%0d_busy_csum", v), {63'd0, busy}, 64'd1);
        send_byte(vecs[v].csum, 1'b0);
      end
      check_end($sformatf("v%0d", v), vecs[v].exp_done, vecs[v].exp_err,
                vecs[v].nwords, vecs[v].nwords, base);
      tick();
    end

    // Asynchronous reset in the middle of the second word.
    pulse_start();
    send_len(32'd2);
    send_word(32'h00100513, 0, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h05, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wc",    {49'd0, word_count}, 64'd0);
    check("mid_rst_addr",  {50'd0, imem_addr}, 64'd0);
    check("mid_rst_wdata", {32'd0, imem_wdata}, 64'd0);
    check("mid_rst_flags", {60'd0, imem_wren, busy, done, error}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h20, 1'b0);
    check("post_rst_idle", {62'd0, busy, imem_wren}, 64'd0);
    base = wr_count;
    pulse_start();
    send_len(32'd1);
    send_word(32'hDEADBEEF, 0, 1'b0);
    send_byte(8'h22, 1'b0);
    check_end("after_rst", 1'b1, 1'b0, 1, 1, base);

    // Back-to-back bytes with start pulses sprinkled through the load.
    base = wr_count;
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    send_word(32'h11223344, 0, 1'b1);
    send_word(32'h55667788, 1, 1'b1);
    pulse_start();
    check("start_busy_ignored", {62'd0, busy, imem_wren}, 64'd2);
    send_word(32'h99AABBCC, 2, 1'b0);
    send_byte(8'hCC, 1'b1);
    check_end("interleave", 1'b1, 1'b0, 3, 3, base);
    tick();
    pulse_start();
    check("restart_done", {62'd0, done, busy}, 64'd1);
    check("restart_wc", {49'd0, word_count}, 64'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction stream: receives a program image as a byte stream, typically from the UART receiver.
- Assembles each group of 4 bytes into a little-endian 32-bit RISC-V instruction word and writes it into instruction memory at consecutive word addresses.
- The instruction memory later feeds the fetch stage and the instruction decoder.
- Holds the core out of reset via busy/done until the image is loaded and checksum-verified.

Parameters:
- ADDR_WIDTH, 14, word-address width of instruction memory; MAX_WORDS = 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- imem_wren  out  1  instruction memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  assembled instruction word.
- busy  out  1  high while in LEN, DATA or CSUM.
- done  out  1  high in DONE (load succeeded); held until next start or rst.
- error  out  1  high in ERR; held until next start or rst.
- word_count  out  ADDR_WIDTH+1  number of words written so far in the current load.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-load):
  - state=IDLE.
  - imem_wren=0, imem_addr=0, imem_wdata=0.
  - busy=0, done=0, error=0, word_count=0.
  - byte counter=0, length=0, checksum=0.
- Image format:
  - 4 length bytes, little-endian, N in words.
  - then 4*N data bytes, little-endian per word.
  - then 1 checksum byte = XOR of all 4*N data bytes. Length bytes are excluded from the checksum.
- State IDLE:
  - start -> LEN.
  - On entry to LEN: clear byte counter, checksum, word_count and imem_addr; drop done and error.
- State LEN:
  - Each rx_valid shifts rx_data into length[8*k+:8], k = byte counter 0..3.
  - After the 4th byte, evaluate the assembled N:
    - N==0 or N>MAX_WORDS -> ERR.
    - otherwise -> DATA.
- State DATA:
  - Each rx_valid places rx_data into word byte lane k (k = byte index 0..3) and XORs rx_data into the checksum.
  - On the 4th byte:
    - Next cycle: imem_wren=1, imem_wdata=assembled word, imem_addr=word_count (pre-increment value).
    - word_count increments in that same cycle.
    - Latency: 1 cycle from the 4th-byte rx_valid to the imem_wren pulse.
  - After the pulse: imem_addr holds its value and imem_wdata holds the last word.
  - When word_count reaches N -> CSUM.
  - Back-to-back rx_valid on consecutive cycles must be accepted; no byte is dropped.
- State CSUM:
  - Next rx_valid compares rx_data with the checksum.
    - equal -> DONE.
    - mismatch -> ERR.
- DONE / ERR:
  - rx_valid is ignored.
  - start -> LEN (restart).
- start while busy is ignored; the load in progress continues.
- rx_valid in IDLE is ignored.
- imem_wren is never asserted outside the cycle after the 4th data byte of a word.
- ERR does not undo writes already performed.
- Address wrap is impossible: N≤MAX_WORDS, so the maximum imem_addr is MAX_WORDS-1 and word_count can reach MAX_WORDS, which needs the extra bit.

Test Plan:
- Reset, start, bytes 02 00 00 00 | 13 05 10 00 | 93 05 20 00 | checksum 13^05^10^00^93^05^20^00=B0 ->
  - imem writes 0x00100513@0, then 0x00200593@1;
  - word_count=2; done=1; error=0; busy=0.
- Same image with checksum 0xB1 -> both words written; error=1; done=0.
- Length 00 00 00 00 -> ERR right after the 4th byte; no imem_wren.
- Length MAX_WORDS+1 (0x00004001 for ADDR_WIDTH=14) -> ERR; no imem_wren.
- Assert rst after 6 data bytes -> all outputs 0 and IDLE immediately. Then start with a full 1-word image -> word written at address 0; done=1.
- Bytes on every consecutive cycle with start pulses interleaved mid-load ->
  - start has no effect;
  - every word is written exactly once, 1 cycle after its 4th byte;
  - after done, a new start clears done and word_count.
